adder_nbit_seq: RTL and testbench
=================================

ADDER_NBIT_SEQ -- requirements
Module: adder_nbit_seq

Interface
REQ-001 Parameter NUM_BITS, default 16: operand and sum width; SHALL be >= 2.
REQ-002 Parameter CHUNK_BITS, default 4: bits added per cycle; SHALL divide NUM_BITS exactly. K = NUM_BITS/CHUNK_BITS.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin an operation; sampled on the rising edge.
REQ-006 a  input  NUM_BITS  operand A, unsigned or two's complement.
REQ-007 b  input  NUM_BITS  operand B, unsigned or two's complement.
REQ-008 carry_in  input  1  carry into bit 0.
REQ-009 sub  input  1  0 = compute a + b + carry_in; 1 = compute a + ~b + carry_in.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse marking a new valid result.
REQ-012 sum  output  NUM_BITS  registered result.
REQ-013 overflow  output  1  carry out of bit NUM_BITS-1.
REQ-014 signed_ovf  output  1  two's-complement overflow flag.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-016 In IDLE with start=1, the block SHALL capture a, b (inverted when sub=1), carry_in and sub, clear the chunk index to 0 and the partial sum, and enter ADD.
REQ-017 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-018 Each ADD cycle SHALL add chunk i of the captured operands plus the running carry, store CHUNK_BITS result bits at chunk position i, update the carry, and increment i.
REQ-019 After the ADD cycle with i = K-1, the FSM SHALL enter DONE; ADD SHALL last exactly K cycles.
REQ-020 On entry to DONE, sum, overflow and signed_ovf SHALL load together; DONE SHALL last one cycle and then return to IDLE.
REQ-021 Timing: start is sampled at edge t0; busy=1 for cycles t0+1..t0+K; done=1 in cycle t0+K+1 only; busy=0 while done=1.
REQ-022 overflow SHALL equal the final carry out; when sub=1 and carry_in=1, overflow=1 means no borrow.
REQ-023 signed_ovf SHALL be 1 iff the MSBs of the two effective operands are equal and differ from the MSB of sum.
REQ-024 sum and the flags SHALL hold their last result until the next DONE and SHALL NOT change during ADD.
REQ-025 start SHALL be ignored in ADD and DONE; changes to a, b, carry_in or sub after capture SHALL NOT affect the operation in progress.
REQ-026 start held high continuously SHALL begin a new operation at each return to IDLE, so there is one operation per K+2 cycles.
REQ-027 When K=1 (CHUNK_BITS=NUM_BITS), the block SHALL follow the same IDLE->ADD->DONE sequence with a single ADD cycle.
REQ-028 All arithmetic is modulo 2^NUM_BITS; the carry beyond the MSB appears only on overflow.

Reset
REQ-029 When rst=1 at a rising edge, the FSM SHALL go to IDLE and busy, done, sum, overflow, signed_ovf, the chunk index and the internal carry SHALL all clear to 0.
REQ-030 rst SHALL take priority over start and over any operation in progress; an aborted operation SHALL produce no done pulse.

Verification (NUM_BITS=16, CHUNK_BITS=4, K=4)
REQ-031 rst=1 for 2 cycles with start=1 -> busy=0, done=0, sum=0x0000, overflow=0, signed_ovf=0.
REQ-032 a=0xFFFF, b=0x0001, carry_in=0, sub=0, start pulsed at t0 -> busy during t0+1..t0+4; done at t0+5; sum=0x0000, overflow=1, signed_ovf=0.
REQ-033 a=0x7FFF, b=0x0001, carry_in=0, sub=0 -> sum=0x8000, overflow=0, signed_ovf=1.
REQ-034 a=0x0005, b=0x0007, carry_in=1, sub=1 -> sum=0xFFFE, overflow=0, signed_ovf=0.
REQ-035 Start with a=0x1234, b=0x1111; at t0+2 drive start=1 with a=0xFFFF -> the second start is ignored; a single done at t0+5 with sum=0x2345; the previous sum value is held during t0+1..t0+4.
REQ-036 rst=1 during the second ADD cycle -> next cycle in IDLE, all outputs 0, no done; then a=0x0003, b=0x0004 -> sum=0x0007 five cycles after start. Repeat with CHUNK_BITS=16 -> done at t0+2.

Source files
------------

// File: rtl/adder_nbit_seq.sv
// Multi-cycle ripple adder/subtractor: adds one CHUNK_BITS slice per cycle.
// Result and flags load together when the last slice completes.
module adder_nbit_seq #(
    parameter int NUM_BITS   = 16,
    parameter int CHUNK_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    input  logic                sub,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] sum,
    output logic                overflow,
    output logic                signed_ovf
);

    localparam int K  = NUM_BITS / CHUNK_BITS;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST = IW'(K - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_BITS-1:0] a_q, a_d;
    logic [NUM_BITS-1:0] b_q, b_d;
    logic [NUM_BITS-1:0] psum_q, psum_d;
    logic [NUM_BITS-1:0] sum_q, sum_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                carry_q, carry_d;
    logic                ovf_q, ovf_d;
    logic                sovf_q, sovf_d;

    logic [CHUNK_BITS-1:0] chunk_a;
    logic [CHUNK_BITS-1:0] chunk_b;
    logic [CHUNK_BITS-1:0] chunk_r;
    logic                  chunk_c;

    // One slice of the ripple: current chunk of both operands plus carry.
    always_comb begin
        chunk_a = a_q[int'(idx_q)*CHUNK_BITS +: CHUNK_BITS];
        chunk_b = b_q[int'(idx_q)*CHUNK_BITS +: CHUNK_BITS];
        {chunk_c, chunk_r} = {1'b0, chunk_a} + {1'b0, chunk_b}
                           + {{CHUNK_BITS{1'b0}}, carry_q};
    end

    // Next-state and datapath updates; the visible result only changes
    // on the last ADD cycle so it holds steady throughout the operation.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        sovf_d  = sovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = carry_in;
                    idx_d   = '0;
                    psum_d  = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                psum_d[int'(idx_q)*CHUNK_BITS +: CHUNK_BITS] = chunk_r;
                carry_d = chunk_c;
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    state_d = DONE;
                    sum_d   = psum_d;
                    ovf_d   = chunk_c;
                    sovf_d  = (a_q[NUM_BITS-1] == b_q[NUM_BITS-1])
                           && (psum_d[NUM_BITS-1] != a_q[NUM_BITS-1]);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            sovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            sovf_q  <= sovf_d;
        end
    end

    // Status decoded straight from the registered state.
    always_comb begin
        busy       = (state_q == ADD);
        done       = (state_q == DONE);
        sum        = sum_q;
        overflow   = ovf_q;
        signed_ovf = sovf_q;
    end

endmodule

// File: tb/tb_adder_nbit_seq.sv
// Bench for adder_nbit_seq: 4-bit chunks (K=4) and full-width (K=1).
// Expected results come from plain wide arithmetic on the operands.
module tb_adder_nbit_seq;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;

    logic         busy0, done0, ovf0, sovf0;
    logic [N-1:0] sum0;
    logic         busy1, done1, ovf1, sovf1;
    logic [N-1:0] sum1;

    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] prev0  = '0;

    always #5 clk = ~clk;

    adder_nbit_seq #(.NUM_BITS(N), .CHUNK_BITS(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a(a), .b(b), .carry_in(cin), .sub(sub),
        .busy(busy0), .done(done0), .sum(sum0),
        .overflow(ovf0), .signed_ovf(sovf0)
    );

    adder_nbit_seq #(.NUM_BITS(N), .CHUNK_BITS(16)) dut1 (
        .clk(clk), .rst(rst), .start(start),
        .a(a), .b(b), .carry_in(cin), .sub(sub),
        .busy(busy1), .done(done1), .sum(sum1),
        .overflow(ovf1), .signed_ovf(sovf1)
    );

    task automatic chk(input string tag, input logic [N-1:0] obs,
                       input logic [N-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full operation; optional noise scrambles inputs while busy.
    task automatic run(input logic [N-1:0] ra, input logic [N-1:0] rb,
                       input logic rc, input logic rs,
                       input bit noise, input bit which);
        logic [N:0]   full;
        logic [N-1:0] be;
        logic         sv;
        int           k;
        be   = rs ? ~rb : rb;
        full = {1'b0, ra} + {1'b0, be} + {{N{1'b0}}, rc};
        sv   = (ra[N-1] == be[N-1]) && (full[N-1] != ra[N-1]);
        k    = which ? 1 : 4;
        a = ra; b = rb; cin = rc; sub = rs; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < k; i++) begin
            if (noise) begin
                a     = N'($urandom);
                b     = N'($urandom);
                cin   = 1'($urandom);
                sub   = 1'($urandom);
                start = 1'($urandom);
            end
            chk("busy", which ? busy1 : busy0, 1);
            chk("done_early", which ? done1 : done0, 0);
            if (!which) chk("sum_hold", sum0, prev0);
            tick();
        end
        start = 1'b0;
        chk("done", which ? done1 : done0, 1);
        chk("busy_at_done", which ? busy1 : busy0, 0);
        chk("sum", which ? sum1 : sum0, full[N-1:0]);
        chk("overflow", which ? ovf1 : ovf0, full[N]);
        chk("signed_ovf", which ? sovf1 : sovf0, sv);
        tick();
        chk("done_once", which ? done1 : done0, 0);
        chk("sum_after", which ? sum1 : sum0, full[N-1:0]);
        if (!which) prev0 = full[N-1:0];
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_sum", sum0, 16'h0000);
        chk("rst_ovf", ovf0, 0);
        chk("rst_sovf", sovf0, 0);
        rst = 1'b0; start = 1'b0;
        repeat (2) tick();

        run(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        run(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        run(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 1'b0);

        // Second start mid-operation must be ignored.
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_busy1", busy0, 1);
        chk("ign_hold1", sum0, prev0);
        tick();
        start = 1'b1; a = 16'hFFFF;
        chk("ign_busy2", busy0, 1);
        tick();
        start = 1'b0;
        chk("ign_hold2", sum0, prev0);
        tick();
        chk("ign_hold3", sum0, prev0);
        chk("ign_nodone", done0, 0);
        tick();
        chk("ign_done", done0, 1);
        chk("ign_sum", sum0, 16'h2345);
        tick();
        chk("ign_single", done0, 0);
        prev0 = 16'h2345;
        repeat (3) tick();

        // Abort with reset during the second ADD cycle.
        a = 16'h4321; b = 16'h1111; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("abort_busy_pre", busy0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0);
        chk("abort_sum", sum0, 16'h0000);
        chk("abort_ovf", ovf0, 0);
        chk("abort_sovf", sovf0, 0);
        for (int i = 0; i < 6; i++) begin
            chk("abort_nodone", done0, 0);
            tick();
        end
        prev0 = '0;
        run(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);

        // Continuous start: one operation every K+2 cycles.
        a = 16'h0001; b = 16'h0002; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick();
        for (int j = 0; j < 18; j++) begin
            chk("cont_done", done0, (j % 6 == 4) ? 1 : 0);
            tick();
        end
        start = 1'b0;
        repeat (6) tick();
        chk("cont_sum", sum0, 16'h0003);
        prev0 = 16'h0003;

        for (int i = 0; i < 20; i++) begin
            run(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom),
                1'b1, 1'b0);
        end

        run(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b1);
        run(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom),
                1'b0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
